// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry holding register,
// optional even/odd parity, 1 or 2 stop bits, and back-to-back framing.
module uart_tx #(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600,
  parameter int PARITY    = 1,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       donetx
);

  localparam int CLKS_PER_BIT = clk_freq / baud_rate;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic          stop_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [7:0]    hold;
  logic          hold_full;
  logic          last_cnt;
  logic          accept;

  function automatic logic parity_of(input logic [7:0] b);
    return (PARITY == 2) ? ~^b : ^b;
  endfunction

  assign last_cnt = (cnt == CW'(CLKS_PER_BIT - 1));
  assign accept   = tx_valid && !hold_full;
  assign tx_ready = !hold_full;

  // Holding register, bit-time counter and frame sequencing with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      donetx    <= 1'b0;
    end else begin
      donetx <= 1'b0;
      if (accept) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end
      case (state)
        IDLE: begin
          tx   <= 1'b1;
          busy <= 1'b0;
          cnt  <= '0;
          if (hold_full) begin
            shreg     <= hold;
            par_bit   <= parity_of(hold);
            hold_full <= 1'b0;
            state     <= START;
            tx        <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (last_cnt) begin
            cnt     <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (last_cnt) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= shreg >> 1;
              tx      <= shreg[1];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PAR: begin
          if (last_cnt) begin
            cnt      <= '0;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (last_cnt) begin
            cnt <= '0;
            if ((STOP_BITS == 1) || stop_idx) begin
              donetx <= 1'b1;
              // A pending byte starts its frame immediately, with no idle bit.
              if (hold_full) begin
                shreg     <= hold;
                par_bit   <= parity_of(hold);
                hold_full <= 1'b0;
                tx        <= 1'b0;
                state     <= START;
              end else begin
                busy  <= 1'b0;
                state <= IDLE;
              end
            end else begin
              stop_idx <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives four uart_tx configurations with shared stimulus and
// checks every cycle against a frame-schedule reference model.
module tb_uart_tx;

  localparam int CPB = 104;
  localparam int NI  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic [NI-1:0] tx_w, busy_w, done_w, rdy_w;

  int par_m  [NI] = '{1, 2, 0, 1};
  int stop_m [NI] = '{1, 1, 1, 2};

  int compared = 0;
  int mismatched = 0;
  int n = 0;

  // reference model state: frame in flight and pending byte per instance
  bit       cur_v  [NI];
  int       cur_s  [NI];
  bit [7:0] cur_b  [NI];
  bit       pend_v [NI];
  int       pend_s [NI];
  bit [7:0] pend_b [NI];
  bit       m_ready[NI];
  bit       prev_busy[NI];
  int       fstart [NI];

  always #5 clk = ~clk;

  uart_tx #(.clk_freq(1000000), .baud_rate(9600), .PARITY(1), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .donetx(done_w[0]));
  uart_tx #(.clk_freq(1000000), .baud_rate(9600), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .donetx(done_w[1]));
  uart_tx #(.clk_freq(1000000), .baud_rate(9600), .PARITY(0), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .donetx(done_w[2]));
  uart_tx #(.clk_freq(1000000), .baud_rate(9600), .PARITY(1), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(rdy_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .donetx(done_w[3]));

  task automatic check(input string tag, input int observed, input int expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s at edge %0d: got 0x%0h, want 0x%0h", tag, n, observed, expected);
    end
  endtask

  function automatic int frame_len(input int i);
    return (10 + ((par_m[i] != 0) ? 1 : 0) + (stop_m[i] - 1)) * CPB;
  endfunction

  // Serial level for bit slot k of a frame: start, 8 data LSB first, parity, stops
  function automatic logic exp_bit(input int i, input bit [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && par_m[i] != 0) return (par_m[i] == 1) ? ^b : ~^b;
    return 1'b1;
  endfunction

  // One clock edge: advance the model using the inputs present at that edge, then compare
  task automatic step();
    bit acc, dn;
    logic [3:0] want;
    @(posedge clk);
    #1;
    n++;
    for (int i = 0; i < NI; i++) begin
      if (rst) begin
        cur_v[i]  = 1'b0;
        pend_v[i] = 1'b0;
        fstart[i] = -1;
        want = 4'b1001;
      end else begin
        acc = tx_valid && m_ready[i];
        dn  = cur_v[i] && (n == cur_s[i] + frame_len(i));
        if (dn) cur_v[i] = 1'b0;
        if (pend_v[i] && pend_s[i] == n) begin
          cur_v[i]  = 1'b1;
          cur_s[i]  = n;
          cur_b[i]  = pend_b[i];
          pend_v[i] = 1'b0;
        end
        if (acc) begin
          pend_v[i] = 1'b1;
          pend_b[i] = tx_data;
          pend_s[i] = cur_v[i] ? cur_s[i] + frame_len(i) : n + 1;
        end
        want = {cur_v[i] ? exp_bit(i, cur_b[i], (n - cur_s[i]) / CPB) : 1'b1,
                cur_v[i], dn, !pend_v[i]};
      end
      m_ready[i] = want[0];
      check($sformatf("outs%0d{tx,busy,done,rdy}", i),
            int'({tx_w[i], busy_w[i], done_w[i], rdy_w[i]}), int'(want));
      // independent frame-length check: busy rise (or back-to-back restart) to donetx
      if (!rst) begin
        if (busy_w[i] && !prev_busy[i]) fstart[i] = n;
        if (done_w[i]) begin
          if (fstart[i] >= 0) check($sformatf("frame_len%0d", i), n - fstart[i], frame_len(i));
          fstart[i] = busy_w[i] ? n : -1;
        end
      end
      prev_busy[i] = busy_w[i];
    end
  endtask

  task automatic send(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      cur_v[i] = 0; pend_v[i] = 0; m_ready[i] = 1; prev_busy[i] = 0; fstart[i] = -1;
      cur_s[i] = 0; pend_s[i] = 0; cur_b[i] = 0; pend_b[i] = 0;
    end
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    send(8'hA5);
    repeat (1300) step();
    send(8'h07);
    repeat (1300) step();

    // back-to-back: 0x00 then 0xFF with tx_valid held
    tx_data = 8'h00; tx_valid = 1'b1;
    step();
    tx_data = 8'hFF;
    repeat (20) step();
    tx_valid = 1'b0;
    repeat (2600) step();

    // reset in the middle of a frame, then a clean frame
    send(8'h5A);
    repeat (499) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    send(8'h3C);
    repeat (1400) step();

    // pending byte held; a valid pulse while tx_ready is low must be dropped
    send(8'h81);
    step();
    send(8'h42);
    repeat (100) step();
    send(8'hEE);
    repeat (2800) step();

    // random traffic with occasional resets (valid may be high during reset)
    repeat (12000) begin
      tx_valid = ($urandom_range(7) == 0);
      tx_data  = 8'($urandom);
      rst      = ($urandom_range(2999) == 0);
      step();
    end
    tx_valid = 1'b0; rst = 1'b0;
    repeat (1400) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
